// File: rtl/uart_rx_fifo_cfg.sv
// uart_rx_fifo_cfg: parametrised UART receiver with FIFO output.
//
// The receiver has these parts:
//   - a programmable baud-tick generator;
//   - a 2-flop input synchroniser;
//   - an oversampling receive FSM with configurable data width, parity and
//     stop bits;
//   - a first-word-fall-through FIFO with a valid/ready output.
// Each FIFO word carries its own parity and framing error flags. A sticky
// overrun flag records frames dropped while the FIFO was full.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   baud_div     tick divisor, tick period = baud_div + 1 clocks
//   rx           asynchronous serial input, idle high
//   rx_ready     consumer accepts the head word this cycle
//   clr_overrun  one-cycle pulse that clears overrun
//   rx_valid     FIFO not empty
//   rx_data      head word data (0 while empty)
//   rx_par_err   parity error of the head word (0 while empty)
//   rx_frm_err   framing error of the head word (0 while empty)
//   overrun      sticky: a completed frame was dropped on a full FIFO
//   fifo_count   number of occupied FIFO entries
module uart_rx_fifo_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx,
    input  logic                          rx_ready,
    input  logic                          clr_overrun,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_par_err,
    output logic                          rx_frm_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned S_W    = $clog2(OVERSAMPLE);
    localparam int unsigned N_W    = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = DATA_BITS + 2;

    localparam logic [S_W-1:0]   S_HALF    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0]   N_LAST    = N_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } state_t;

    // Registers
    logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    state_t               state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 valid_q, valid_d;
    logic [WORD_W-1:0]    head_q, head_d;

    // Combinational helpers
    logic              tick;
    logic              rx_s;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic              frm_next;
    logic              par_ones;
    logic              pop;
    logic              full;
    logic              do_push;
    logic              drop;

    // Baud tick: live compare, so a smaller new divisor runs to 2^DIV_W first.
    always_comb begin
        tick       = (tick_cnt_q == baud_div);
        tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    end

    // Two-flop synchroniser on the serial input.
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        rx_s    = sync2_q;
    end

    // Receive FSM: start validation at mid start bit, then one sample per bit.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        push      = 1'b0;
        push_word = '0;
        frm_next  = frm_err_q | ~rx_s;
        par_ones  = (^shift_q) ^ rx_s;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_HALF) begin
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            s_d       = '0;
                            n_d       = '0;
                            par_err_d = 1'b0;
                            frm_err_d = 1'b0;
                        end else begin
                            // Line went back high: treat as a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        n_d     = n_q + N_W'(1);
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                        // par_ones = 1 when data+parity holds an odd number of 1s.
                        par_err_d = (PARITY == 1) ? ~par_ones : par_ones;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d       = '0;
                        frm_err_d = frm_next;
                        if (stop_q == STOP_LAST) begin
                            push      = 1'b1;
                            push_word = {frm_next, par_err_q, shift_q};
                            state_d   = frm_next ? ST_BRK_WAIT : ST_IDLE;
                        end else begin
                            stop_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_BRK_WAIT: begin
                // A held-low line yields one word, then waits for idle.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO: a full FIFO still accepts a push when the head is popped the same cycle.
    always_comb begin
        pop     = valid_q && rx_ready;
        full    = (count_q == CNT_FULL);
        do_push = push && (!full || pop);
        drop    = push && full && !pop;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_word;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);

        // A drop in the same cycle as clr_overrun leaves overrun set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        // Head is registered from next-state storage, so outputs read 0 when empty.
        valid_d = (count_d != '0);
        head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
        end
    end

    assign rx_valid   = valid_q;
    assign rx_data    = head_q[DATA_BITS-1:0];
    assign rx_par_err = head_q[DATA_BITS];
    assign rx_frm_err = head_q[DATA_BITS+1];
    assign overrun    = overrun_q;
    assign fifo_count = count_q;

endmodule
